// File: rtl/chimp_pkg.sv
// ============================================================================
// Module  : chimp_pkg
// Brief   : Shared types and constants for the chimp memory-test board
//           datapath: default geometry, cell type, state encoding and the
//           LFSR feedback taps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package chimp_pkg;

  // Default board geometry: 8x5 grid, 6-bit cell index.
  localparam int N_CELLS_DEF = 40;
  localparam int CELL_W_DEF  = 6;

  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // A cell holds the number placed on it; 0 means empty.
  typedef logic [4:0] cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    PLAY  = 2'd2
  } state_e;

  // Fibonacci feedback bit: XOR of the tapped register bits.
  function automatic logic lfsr_feedback(input logic [15:0] r);
    return ^(r & LFSR_TAPS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/chimp_lfsr16.sv
// ============================================================================
// Module  : chimp_lfsr16
// Brief   : 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances one step
//           whenever iStep is high. Reset loads SEED, which must be nonzero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chimp_lfsr16
  import chimp_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        iStep,
  output logic [15:0] oRand
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift left and insert the feedback bit when stepping.
  always_comb begin
    lfsr_d = lfsr_q;
    if (iStep) begin
      lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk) begin
    if (!iResetn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign oRand = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/chimp_board_datapath.sv
// ============================================================================
// Module  : chimp_board_datapath
// Brief   : Board datapath for the chimp memory test. Places numbers
//           1..iLevel on distinct pseudo-random cells, judges player clicks
//           and serves a registered cell read port for the renderer.
//           Build option CHIMP_FREE_RUN_SEED_EN: when defined the LFSR runs
//           every cycle; when undefined it only steps while placing, making
//           layouts a pure function of SEED.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chimp_board_datapath
  import chimp_pkg::*;
#(
  parameter int          N_CELLS   = N_CELLS_DEF,
  parameter int          CELL_W    = CELL_W_DEF,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic              clk,
  input  logic              iResetn,
  input  logic              iResetBoard,
  input  logic              iLoadEnable,
  input  logic [4:0]        iLevel,
  input  logic [4:0]        iNumToChoose,
  input  logic              iClickValid,
  input  logic [CELL_W-1:0] iClickCell,
  input  logic [CELL_W-1:0] iReadCell,
  output logic [4:0]        oReadNum,
  output logic              oLoadBusy,
  output logic              oChoseCorrectNum,
  output logic              oChoseWrongNum,
  output logic [4:0]        oPlaced
);

  localparam int                TRY_W   = $clog2(MAX_TRIES + 2);
  localparam logic [TRY_W-1:0]  TRY_LIM = TRY_W'(MAX_TRIES);
  localparam int                CW1     = CELL_W + 1;
  localparam logic [CELL_W:0]   NC_W    = CW1'(N_CELLS);

  state_e            state_q, state_d;
  cell_t             cells_q [N_CELLS];
  cell_t             cells_d [N_CELLS];
  logic              armed_q, armed_d;
  logic [4:0]        level_q, level_d;
  logic [4:0]        placed_q, placed_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              correct_q, correct_d;
  logic              wrong_q, wrong_d;
  cell_t             read_q, read_d;

  logic [15:0]       rand_w;
  logic              unused_rand;
  logic              step;
  logic              start;
  logic [CELL_W-1:0] cand;
  logic [CELL_W-1:0] cand_mod;
  logic              cand_ok;
  logic              fb_found;
  logic [CELL_W-1:0] fb_idx;
  logic [CELL_W:0]   fb_pos;
  logic [CELL_W-1:0] place_idx;
  logic              click_in_range;
  cell_t             click_val;

`ifdef CHIMP_FREE_RUN_SEED_EN
  assign step = 1'b1;
`else
  assign step = (state_q == PLACE);
`endif

  chimp_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .iResetn (iResetn),
    .iStep   (step),
    .oRand   (rand_w)
  );

  // Only the low CELL_W bits form the candidate cell.
  assign unused_rand = ^rand_w[15:CELL_W];
  assign cand        = rand_w[CELL_W-1:0];
  assign cand_mod    = CELL_W'(int'(cand) % N_CELLS);
  assign cand_ok     = ({1'b0, cand} < NC_W) ? (cells_q[cand] == '0) : 1'b0;

  // A load starts only from IDLE/PLAY with the armed flag set, so a held
  // iLoadEnable cannot retrigger placement.
  assign start = iResetn && !iResetBoard && iLoadEnable && armed_q &&
                 (state_q != PLACE);

  assign click_in_range = ({1'b0, iClickCell} < NC_W);
  assign click_val      = click_in_range ? cells_q[iClickCell] : '0;

  // Fallback probe: first empty cell at or after cand_mod, wrapping.
  always_comb begin
    fb_found = 1'b0;
    fb_idx   = '0;
    fb_pos   = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      fb_pos = {1'b0, cand_mod} + CW1'(i);
      if (fb_pos >= NC_W) begin
        fb_pos = fb_pos - NC_W;
      end
      if (!fb_found && (cells_q[fb_pos[CELL_W-1:0]] == '0)) begin
        fb_found = 1'b1;
        fb_idx   = fb_pos[CELL_W-1:0];
      end
    end
  end

  // Next-state logic: board reset, load start, placement and click judging.
  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    armed_d   = armed_q;
    level_d   = level_q;
    placed_d  = placed_q;
    tries_d   = tries_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    place_idx = cand;

    if (iResetBoard) begin
      for (int i = 0; i < N_CELLS; i++) begin
        cells_d[i] = '0;
      end
      state_d  = IDLE;
      placed_d = '0;
      tries_d  = '0;
    end else if (start) begin
      state_d  = PLACE;
      level_d  = iLevel;
      placed_d = '0;
      tries_d  = '0;
    end else begin
      case (state_q)
        PLACE: begin
          if (placed_q == level_q) begin
            state_d = PLAY;
          end else if (cand_ok || ((tries_q == TRY_LIM) && fb_found)) begin
            place_idx          = cand_ok ? cand : fb_idx;
            cells_d[place_idx] = placed_q + 5'd1;
            placed_d           = placed_q + 5'd1;
            tries_d            = '0;
            if ((placed_q + 5'd1) == level_q) begin
              state_d = PLAY;
            end
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
        PLAY: begin
          if (iClickValid && (iNumToChoose != '0) && click_in_range) begin
            if (click_val == iNumToChoose) begin
              cells_d[iClickCell] = '0;
              correct_d           = 1'b1;
            end else if (click_val != '0) begin
              wrong_d = 1'b1;
            end
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      armed_d = 1'b0;
    end
    if (!iLoadEnable || iResetBoard) begin
      armed_d = 1'b1;
    end
  end

  // Registered read port; out-of-range addresses read as empty.
  always_comb begin
    read_d = '0;
    if ({1'b0, iReadCell} < NC_W) begin
      read_d = cells_q[iReadCell];
    end
  end

  // State and board registers.
  always_ff @(posedge clk) begin
    if (!iResetn) begin
      state_q   <= IDLE;
      for (int i = 0; i < N_CELLS; i++) begin
        cells_q[i] <= '0;
      end
      armed_q   <= 1'b1;
      level_q   <= '0;
      placed_q  <= '0;
      tries_q   <= '0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      read_q    <= '0;
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      armed_q   <= armed_d;
      level_q   <= level_d;
      placed_q  <= placed_d;
      tries_q   <= tries_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      read_q    <= read_d;
    end
  end

  assign oLoadBusy        = start || (state_q == PLACE);
  assign oPlaced          = placed_q;
  assign oReadNum         = read_q;
  assign oChoseCorrectNum = correct_q;
  assign oChoseWrongNum   = wrong_q;

endmodule

`default_nettype wire

// File: tb/tb_chimp_board_datapath.sv
// ============================================================================
// Module  : tb_chimp_board_datapath
// Brief   : Directed self-checking bench for chimp_board_datapath: reset,
//           deterministic placement, picks, reload, reset during placement
//           and fallback termination on a 32-cell board.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chimp_board_datapath;

  localparam int NC  = 40;
  localparam int CW  = 6;
  localparam int FNC = 32;
  localparam int FCW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main board (default geometry)
  logic          rstn, rboard, lden, cv;
  logic [4:0]    level, ntc;
  logic [CW-1:0] ccell, rcell;
  logic [4:0]    rnum, placed;
  logic          busy, corr, wrong;

  // Fallback board (32 cells, MAX_TRIES=2)
  logic           f_rstn, f_rboard, f_lden, f_cv;
  logic [4:0]     f_level, f_ntc;
  logic [FCW-1:0] f_ccell, f_rcell;
  logic [4:0]     f_rnum, f_placed;
  logic           f_busy, f_corr, f_wrong;

  int tests_run    = 0;
  int tests_failed = 0;
  int board   [NC];
  int layout1 [NC];
  int pos     [32];

  chimp_board_datapath dut (
    .clk              (clk),
    .iResetn          (rstn),
    .iResetBoard      (rboard),
    .iLoadEnable      (lden),
    .iLevel           (level),
    .iNumToChoose     (ntc),
    .iClickValid      (cv),
    .iClickCell       (ccell),
    .iReadCell        (rcell),
    .oReadNum         (rnum),
    .oLoadBusy        (busy),
    .oChoseCorrectNum (corr),
    .oChoseWrongNum   (wrong),
    .oPlaced          (placed)
  );

  chimp_board_datapath #(
    .N_CELLS   (FNC),
    .CELL_W    (FCW),
    .MAX_TRIES (2),
    .SEED      (16'hACE1)
  ) dut_fb (
    .clk              (clk),
    .iResetn          (f_rstn),
    .iResetBoard      (f_rboard),
    .iLoadEnable      (f_lden),
    .iLevel           (f_level),
    .iNumToChoose     (f_ntc),
    .iClickValid      (f_cv),
    .iClickCell       (f_ccell),
    .iReadCell        (f_rcell),
    .oReadNum         (f_rnum),
    .oLoadBusy        (f_busy),
    .oChoseCorrectNum (f_corr),
    .oChoseWrongNum   (f_wrong),
    .oPlaced          (f_placed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read every main-board cell through the read port into board[]/pos[].
  task automatic dump_board();
    for (int v = 0; v < 32; v++) pos[v] = -1;
    for (int c = 0; c < NC; c++) begin
      rcell = CW'(c);
      tick();
      board[c] = int'(rnum);
      if (rnum != 0) pos[rnum] = c;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rboard = 1'b0; lden = 1'b0; cv = 1'b0;
    level = '0; ntc = '0; ccell = '0; rcell = '0;
    tick(); tick();
    tests_run++;
    if ({busy, corr, wrong} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/corr/wrong=%b expected 000", {busy, corr, wrong});
    end
    tests_run++;
    if (placed !== 5'd0 || rnum !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got placed=%0d readnum=%0d expected 0 0", placed, rnum);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_place();
    int cyc, nz, occ, mism;
    for (int run = 0; run < 2; run++) begin
      rstn = 1'b0; lden = 1'b0; rboard = 1'b0;
      tick();
      rstn = 1'b1; rboard = 1'b1;
      tick();
      rboard = 1'b0; lden = 1'b1; level = 5'd4;
      #1;
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL place_start_busy run%0d: got %b expected 1", run, busy);
      end
      cyc = 0;
      tick();
      while (busy === 1'b1 && cyc < 100) begin
        tick();
        cyc++;
      end
      tests_run++;
      if (busy !== 1'b0 || placed !== 5'd4) begin
        tests_failed++;
        $display("FAIL place_done run%0d: got busy=%b placed=%0d expected 0 4", run, busy, placed);
      end
      dump_board();
      nz = 0;
      for (int c = 0; c < NC; c++) if (board[c] != 0) nz++;
      tests_run++;
      if (nz != 4) begin
        tests_failed++;
        $display("FAIL place_count run%0d: got %0d filled cells expected 4", run, nz);
      end
      for (int v = 1; v <= 4; v++) begin
        occ = 0;
        for (int c = 0; c < NC; c++) if (board[c] == v) occ++;
        tests_run++;
        if (occ != 1) begin
          tests_failed++;
          $display("FAIL place_num%0d run%0d: got %0d copies expected 1", v, run, occ);
        end
      end
      if (run == 0) begin
        for (int c = 0; c < NC; c++) layout1[c] = board[c];
      end else begin
        mism = 0;
        for (int c = 0; c < NC; c++) if (board[c] != layout1[c]) mism++;
        tests_run++;
        if (mism != 0) begin
          tests_failed++;
          $display("FAIL layout_repeat: got %0d differing cells expected 0", mism);
        end
      end
    end
  endtask

  task automatic test_wrong_ignored();
    int empty_c;
    // Cell holding 3 clicked while 1 is expected.
    ntc = 5'd1; cv = 1'b1; ccell = CW'(pos[3]);
    tick();
    cv = 1'b0;
    tests_run++;
    if ({corr, wrong} !== 2'b01) begin
      tests_failed++;
      $display("FAIL wrong_pulse: got corr/wrong=%b expected 01", {corr, wrong});
    end
    tick();
    tests_run++;
    if ({corr, wrong} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wrong_one_cycle: got corr/wrong=%b expected 00", {corr, wrong});
    end
    rcell = CW'(pos[3]);
    tick();
    tests_run++;
    if (rnum !== 5'd3) begin
      tests_failed++;
      $display("FAIL wrong_cell_kept: got %0d expected 3", rnum);
    end
    // Empty cell click.
    empty_c = 0;
    while (board[empty_c] != 0) empty_c++;
    cv = 1'b1; ccell = CW'(empty_c);
    tick();
    cv = 1'b0;
    tests_run++;
    if ({corr, wrong} !== 2'b00) begin
      tests_failed++;
      $display("FAIL empty_click: got corr/wrong=%b expected 00", {corr, wrong});
    end
    // No pick active: clicking the 1 does nothing.
    ntc = 5'd0; cv = 1'b1; ccell = CW'(pos[1]);
    tick();
    cv = 1'b0;
    tests_run++;
    if ({corr, wrong} !== 2'b00) begin
      tests_failed++;
      $display("FAIL nopick_click: got corr/wrong=%b expected 00", {corr, wrong});
    end
    // Out-of-range cell.
    ntc = 5'd1; cv = 1'b1; ccell = 6'd45;
    tick();
    cv = 1'b0;
    tests_run++;
    if ({corr, wrong} !== 2'b00) begin
      tests_failed++;
      $display("FAIL oor_click: got corr/wrong=%b expected 00", {corr, wrong});
    end
    rcell = CW'(pos[1]);
    tick();
    tests_run++;
    if (rnum !== 5'd1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL guard_cell1: got num=%0d busy=%b expected 1 0", rnum, busy);
    end
  endtask

  task automatic test_correct_picks();
    int nz;
    for (int n = 1; n <= 4; n++) begin
      ntc = 5'(n); cv = 1'b1; ccell = CW'(pos[n]);
      tick();
      cv = 1'b0;
      tests_run++;
      if ({corr, wrong} !== 2'b10) begin
        tests_failed++;
        $display("FAIL correct_pulse%0d: got corr/wrong=%b expected 10", n, {corr, wrong});
      end
      tick();
      tests_run++;
      if ({corr, wrong} !== 2'b00) begin
        tests_failed++;
        $display("FAIL correct_drop%0d: got corr/wrong=%b expected 00", n, {corr, wrong});
      end
    end
    ntc = 5'd0;
    dump_board();
    nz = 0;
    for (int c = 0; c < NC; c++) if (board[c] != 0) nz++;
    tests_run++;
    if (nz != 0) begin
      tests_failed++;
      $display("FAIL board_cleared: got %0d filled cells expected 0", nz);
    end
  endtask

  task automatic test_reload();
    int cyc, nz, occ, seen_busy;
    lden = 1'b0;
    tick();
    lden = 1'b1; level = 5'd5;
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_start_busy: got %b expected 1", busy);
    end
    cyc = 0;
    tick();
    while (busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (busy !== 1'b0 || placed !== 5'd5) begin
      tests_failed++;
      $display("FAIL reload_done: got busy=%b placed=%0d expected 0 5", busy, placed);
    end
    dump_board();
    nz = 0;
    for (int c = 0; c < NC; c++) if (board[c] != 0) nz++;
    tests_run++;
    if (nz != 5) begin
      tests_failed++;
      $display("FAIL reload_count: got %0d filled cells expected 5", nz);
    end
    for (int v = 1; v <= 5; v++) begin
      occ = 0;
      for (int c = 0; c < NC; c++) if (board[c] == v) occ++;
      tests_run++;
      if (occ != 1) begin
        tests_failed++;
        $display("FAIL reload_num%0d: got %0d copies expected 1", v, occ);
      end
    end
    seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy === 1'b1) seen_busy++;
    end
    tests_run++;
    if (seen_busy != 0 || placed !== 5'd5) begin
      tests_failed++;
      $display("FAIL reentry_guard: got busy_cycles=%0d placed=%0d expected 0 5", seen_busy, placed);
    end
  endtask

  task automatic test_reset_mid_place(input bit use_rstn);
    int cyc, nz;
    rboard = 1'b1; lden = 1'b0;
    tick();
    rboard = 1'b0; lden = 1'b1; level = 5'd10;
    cyc = 0;
    tick();
    while (placed !== 5'd2 && cyc < 200) begin
      tick();
      cyc++;
    end
    tests_run++;
    if (placed !== 5'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midplace_reach rstn=%0d: got placed=%0d busy=%b expected 2 1", use_rstn, placed, busy);
    end
    if (use_rstn) rstn = 1'b0;
    else          rboard = 1'b1;
    ntc = 5'd1; cv = 1'b1; ccell = '0;
    tick();
    cv = 1'b0; ntc = 5'd0;
    tests_run++;
    if ({busy, corr, wrong} !== 3'b000 || placed !== 5'd0) begin
      tests_failed++;
      $display("FAIL midplace_reset rstn=%0d: got busy/corr/wrong=%b placed=%0d expected 000 0",
               use_rstn, {busy, corr, wrong}, placed);
    end
    rstn = 1'b1; rboard = 1'b0; lden = 1'b0;
    dump_board();
    nz = 0;
    for (int c = 0; c < NC; c++) if (board[c] != 0) nz++;
    tests_run++;
    if (nz != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midplace_cleared rstn=%0d: got %0d filled busy=%b expected 0 0", use_rstn, nz, busy);
    end
  endtask

  task automatic test_fallback();
    int cyc, zeros, occ;
    int fb [FNC];
    f_rstn = 1'b0; f_rboard = 1'b0; f_lden = 1'b0; f_cv = 1'b0;
    f_level = '0; f_ntc = '0; f_ccell = '0; f_rcell = '0;
    tick();
    f_rstn = 1'b1; f_rboard = 1'b1;
    tick();
    f_rboard = 1'b0; f_lden = 1'b1; f_level = 5'd31;
    #1;
    tests_run++;
    if (f_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fb_start_busy: got %b expected 1", f_busy);
    end
    cyc = 0;
    tick();
    while (f_busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    tests_run++;
    if (f_busy !== 1'b0 || cyc > 93 || f_placed !== 5'd31) begin
      tests_failed++;
      $display("FAIL fb_terminate: got busy=%b place_cycles=%0d placed=%0d expected 0 <=93 31",
               f_busy, cyc, f_placed);
    end
    for (int c = 0; c < FNC; c++) begin
      f_rcell = FCW'(c);
      tick();
      fb[c] = int'(f_rnum);
    end
    zeros = 0;
    for (int c = 0; c < FNC; c++) if (fb[c] == 0) zeros++;
    tests_run++;
    if (zeros != 1) begin
      tests_failed++;
      $display("FAIL fb_empty_count: got %0d empty cells expected 1", zeros);
    end
    for (int v = 1; v <= 31; v++) begin
      occ = 0;
      for (int c = 0; c < FNC; c++) if (fb[c] == v) occ++;
      tests_run++;
      if (occ != 1) begin
        tests_failed++;
        $display("FAIL fb_num%0d: got %0d copies expected 1", v, occ);
      end
    end
  endtask

  initial begin
    f_rstn = 1'b0; f_rboard = 1'b0; f_lden = 1'b0; f_cv = 1'b0;
    f_level = '0; f_ntc = '0; f_ccell = '0; f_rcell = '0;
    test_reset();
    test_place();
    test_wrong_ignored();
    test_correct_picks();
    test_reload();
    test_reset_mid_place(1'b0);
    test_reset_mid_place(1'b1);
    test_fallback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/chimp_board_datapath.md
Name: chimp_board_datapath

Overview:
- Datapath stage for the chimp memory test; its control FSM sits directly upstream.
- Consumes the FSM's iLoadEnable, iResetBoard, iLevel and iNumToChoose.
- Places numbers 1..iLevel on distinct random grid cells and judges player clicks.
- Returns oLoadBusy, oChoseCorrectNum and oChoseWrongNum to the FSM, and exposes a cell read port for the VGA renderer.

Parameters:
- N_CELLS, 40, number of grid cells (8x5); must be greater than 31.
- CELL_W, 6, width of a cell index; must satisfy 2^CELL_W >= N_CELLS.
- MAX_TRIES, 8, failed random draws allowed before falling back to a linear probe.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- iResetn  in  1  synchronous active-low reset
- iResetBoard  in  1  clear all cells and arm a new load
- iLoadEnable  in  1  load request (level-sensitive, gated by the armed flag)
- iLevel  in  5  count of numbers to place (0..31)
- iNumToChoose  in  5  number expected next; 0 means no pick is active
- iClickValid  in  1  one-cycle click strobe
- iClickCell  in  CELL_W  clicked cell index
- iReadCell  in  CELL_W  renderer read address
- oReadNum  out  5  contents of iReadCell, registered; 0 means empty
- oLoadBusy  out  1  high while placing; the FSM stays in its load state while this is high
- oChoseCorrectNum  out  1  one-cycle pulse: correct pick
- oChoseWrongNum  out  1  one-cycle pulse: wrong pick
- oPlaced  out  5  numbers placed so far

Behaviour:
- **Reset (iResetn=0 at posedge):**
  - All cells are 0, state is IDLE, armed=1, LFSR=SEED.
  - All outputs are 0.
- **States:** IDLE, PLACE, PLAY.
- **iResetBoard=1 (any state):**
  - Next cycle all cells are 0, state is IDLE, armed=1, oPlaced=0.
  - iResetBoard has priority over every other input.
- **Arming:** armed is set whenever iLoadEnable=0 or iResetBoard=1.
- **Start condition:** iLoadEnable=1, iResetBoard=0, armed=1, in IDLE or PLAY.
  - Clears armed.
  - Enters PLACE with k=1.
  - oLoadBusy is driven combinationally high in this start cycle, so the FSM sees it in the same cycle.
- **Re-entry guard:** iLoadEnable held high after placement does not reload, because armed is clear.
- **PLACE, one draw per cycle:**
  - Candidate = LFSR[CELL_W-1:0].
  - Accept when candidate < N_CELLS and that cell is 0: write k, then k++.
  - Otherwise increment the try counter.
  - After MAX_TRIES consecutive rejects, use the lowest-index empty cell at or after (candidate mod N_CELLS), wrapping. The wrap search is combinational.
  - Try counter clears on every accept.
  - The LFSR steps every PLACE cycle; it is 16-bit Fibonacci with taps 16,14,13,11.
- **Leaving PLACE:**
  - When k > iLevel (iLevel sampled at start), go to PLAY and deassert oLoadBusy (registered).
  - iLevel=0: PLACE lasts one cycle and places nothing.
  - oLoadBusy is high in the start cycle and every PLACE cycle.
- **PLAY click judging:** a click is judged only when iClickValid=1, iNumToChoose≠0 and iClickCell < N_CELLS.
  - Cell == iNumToChoose: clear the cell and pulse oChoseCorrectNum the next cycle.
  - Cell nonzero and ≠ iNumToChoose: pulse oChoseWrongNum the next cycle; the cell is unchanged.
  - Cell 0 or out of range: ignored, no pulse.
- **Ignored clicks:** clicks in IDLE or PLACE, or with iNumToChoose=0, are ignored.
- **Pulse exclusivity:** at most one of oChoseCorrectNum and oChoseWrongNum is high in any cycle.
- **Simultaneous events:**
  - Click in the same cycle as iResetBoard: the reset wins and no pulse is produced.
  - Click in the same cycle as a start condition: the click is ignored.
- **Read port:**
  - oReadNum = cell[iReadCell], one-cycle latency.
  - Out-of-range address reads 0.
  - Valid in all states.
- **oPlaced:** equals k-1 during PLACE; holds its value in PLAY.

Optional Feature:
- Macro: CHIMP_FREE_RUN_SEED_EN.
- Defined: the LFSR steps every cycle regardless of state, so player timing adds entropy.
- Undefined: the LFSR steps only in PLACE, so layouts are deterministic from SEED. The bench relies on this mode.

Decomposition:
- Shared package chimp_pkg holds:
  - N_CELLS and CELL_W defaults.
  - typedef cell_t (logic [4:0]).
  - The state enum {IDLE, PLACE, PLAY}.
  - LFSR tap constants.
- One sub-module, chimp_lfsr16: ports clk, iResetn, iStep, oRand[15:0]; SEED parameter.

Test Plan:
- **Deterministic placement:** iResetn pulse, iResetBoard 1→0 with iLoadEnable=1, iLevel=4, macro undefined.
  - oLoadBusy high in the start cycle.
  - Exactly four distinct cells hold 1..4; oPlaced=4 in PLAY.
  - Layout is identical across two runs.
- **Correct picks to completion:** in PLAY, click the cell holding 1 with iNumToChoose=1, then cells 2..4 in order.
  - Four oChoseCorrectNum pulses, each one cycle after its click.
  - All cells read 0 afterwards.
- **Wrong and ignored clicks:**
  - Click the cell holding 3 while iNumToChoose=1 → one oChoseWrongNum pulse; the cell still reads 3.
  - Click an empty cell → no pulse.
- **Level-up reload:** after the board is cleared by picks, drop iLoadEnable for one cycle then raise it with iLevel=5.
  - PLACE re-entered; 5 numbers placed.
  - Holding iLoadEnable high afterwards triggers no second load.
- **Fallback termination:** N_CELLS=32, iLevel=31, MAX_TRIES=2.
  - PLACE completes in at most 31×3 cycles with all 31 numbers present.
- **Reset mid-PLACE:** assert iResetBoard (then, in a separate run, iResetn=0) during PLACE at k=3.
  - Next cycle: IDLE, all cells 0, oLoadBusy=0, no click pulses.
